// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity and 1 or 2 stop bits, with a one-word holding register.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done,
  output logic [2:0]           o_Fsm_State
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = 4;
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_BITS-1:0]  r_hold;
  logic                  r_hold_v;
  logic [DATA_BITS-1:0]  r_sh;
  logic                  r_serial;
  logic                  r_done;

  state_t                w_state_n;
  logic [BAUD_W-1:0]     w_baud_n;
  logic [BIT_W-1:0]      w_bit_n;
  logic                  w_load;
  logic                  w_done_n;
  logic                  w_serial_n;
  logic                  w_bit_end;
  logic                  w_accept;
  logic                  w_parity;

  // Handshake: a word is taken on any rising edge where i_Tx_DV and o_Tx_Ready
  // are both high; o_Tx_Ready is simply "holding register empty", so a pending
  // word is never overwritten and i_Tx_DV is ignored while it waits.
  assign o_Tx_Ready  = ~r_hold_v;
  assign o_Tx_Active = (r_state != S_IDLE);
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Done   = r_done;
  assign o_Fsm_State = r_state;

  assign w_accept  = i_Tx_DV && !r_hold_v;
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_parity  = (PARITY_MODE == 1) ? ~^r_sh : ^r_sh;

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud + 1'b1;
    w_bit_n   = r_bit;
    w_load    = 1'b0;
    w_done_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_n = '0;
        if (r_hold_v) begin
          w_load    = 1'b1;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_n = S_DATA;
          w_baud_n  = '0;
          w_bit_n   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_n = '0;
          if (r_bit == LAST_DATA) begin
            w_bit_n   = '0;
            w_state_n = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_n = S_STOP;
          w_baud_n  = '0;
          w_bit_n   = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_n = '0;
          if (r_bit == LAST_STOP) begin
            w_done_n = 1'b1;
            w_bit_n  = '0;
            // A pending word starts on this same edge: zero idle gap.
            if (r_hold_v) begin
              w_load    = 1'b1;
              w_state_n = S_START;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_baud_n  = '0;
        w_bit_n   = '0;
      end
    endcase

    // Line level is registered from the next state so it changes on the entry edge.
    case (w_state_n)
      S_START:  w_serial_n = 1'b0;
      S_DATA:   w_serial_n = r_sh[w_bit_n[IDX_W-1:0]];
      S_PARITY: w_serial_n = w_parity;
      default:  w_serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_serial <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_baud   <= w_baud_n;
      r_bit    <= w_bit_n;
      r_serial <= w_serial_n;
      r_done   <= w_done_n;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
      r_sh     <= '0;
    end else begin
      if (w_load) begin
        r_sh     <= r_hold;
        r_hold_v <= 1'b0;
      end else if (w_accept) begin
        r_hold   <= i_Tx_Byte;
        r_hold_v <= 1'b1;
      end
    end
  end

  a_legal_params: assert property (@(posedge i_Clock)
    (PARITY_MODE >= 0) && (PARITY_MODE <= 2) && (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
    (DATA_BITS >= 5) && (DATA_BITS <= 9) && (CLKS_PER_BIT >= 2))
    else $error("uart_tx_param: unsupported parameter value");

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2) at 4 clocks
// per bit, line waveforms compared against a frame model built from queued words.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] dv;
  logic [7:0] byte_in [4];
  wire  [3:0] ready, active, serial, done;
  wire  [3:0][2:0] st;

  int tests = 0;
  int fails = 0;

  logic [7:0]   exp_q[$];
  logic [127:0] obs_ser, obs_act, obs_done;
  logic [127:0] exp_ser, exp_act, exp_done;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(byte_in[0]),
    .o_Tx_Ready(ready[0]), .o_Tx_Active(active[0]), .o_Tx_Serial(serial[0]),
    .o_Tx_Done(done[0]), .o_Fsm_State(st[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(byte_in[1]),
    .o_Tx_Ready(ready[1]), .o_Tx_Active(active[1]), .o_Tx_Serial(serial[1]),
    .o_Tx_Done(done[1]), .o_Fsm_State(st[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(byte_in[2]),
    .o_Tx_Ready(ready[2]), .o_Tx_Active(active[2]), .o_Tx_Serial(serial[2]),
    .o_Tx_Done(done[2]), .o_Fsm_State(st[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[3]), .i_Tx_Byte(byte_in[3][6:0]),
    .o_Tx_Ready(ready[3]), .o_Tx_Active(active[3]), .o_Tx_Serial(serial[3]),
    .o_Tx_Done(done[3]), .o_Fsm_State(st[3]));

  function automatic int db(input int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function automatic int pm(input int k);
    return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
  endfunction
  function automatic int sb(input int k);
    return (k == 3) ? 2 : 1;
  endfunction
  function automatic int flen(input int k);
    return (1 + db(k) + ((pm(k) != 0) ? 1 : 0) + sb(k)) * CPB;
  endfunction

  // Reference: expected line/active/done per sample for nwords queued frames.
  task automatic build_expect(input int k, input int nwords, input int n);
    bit bits[$];
    logic [7:0] w;
    int c, ones;
    exp_ser = '0; exp_act = '0; exp_done = '0;
    for (int i = 0; i < n; i++) exp_ser[i] = 1'b1;
    c = 0;
    for (int f = 0; f < nwords; f++) begin
      if (exp_q.size() == 0) begin
        fails++; tests++;
        $display("FAIL scoreboard k=%0d: expected queue empty, needed word %0d", k, f);
        return;
      end
      w = exp_q.pop_front();
      bits.delete();
      bits.push_back(1'b0);
      ones = 0;
      for (int i = 0; i < db(k); i++) begin
        bits.push_back(w[i]);
        ones += int'(w[i]);
      end
      if (pm(k) == 2) bits.push_back((ones % 2) == 1);
      if (pm(k) == 1) bits.push_back((ones % 2) == 0);
      for (int i = 0; i < sb(k); i++) bits.push_back(1'b1);
      foreach (bits[b]) begin
        for (int r = 0; r < CPB; r++) begin
          if (c < n) begin
            exp_ser[c] = bits[b];
            exp_act[c] = 1'b1;
          end
          c++;
        end
      end
      if (c < n) exp_done[c] = 1'b1;
    end
  endtask

  task automatic capture(input int k, input int n);
    obs_ser = '0; obs_act = '0; obs_done = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs_ser[c]  = serial[k];
      obs_act[c]  = active[k];
      obs_done[c] = done[k];
    end
  endtask

  // Called just after a negedge; waits (bounded) for ready, presents one word.
  task automatic offer(input int k, input logic [7:0] d);
    int n = 0;
    while (!ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!ready[k]) begin
      fails++;
      $display("FAIL ready_timeout k=%0d: ready=%b after %0d cycles, required 1", k, ready[k], n);
    end
    dv[k] = 1'b1;
    byte_in[k] = d;
    exp_q.push_back(d);
    @(negedge clk);
    dv[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input logic [7:0] d);
    int f = flen(k);
    offer(k, d);
    capture(k, f + 2);
    build_expect(k, 1, f + 2);
    tests++;
    if (obs_ser !== exp_ser) begin
      fails++;
      $display("FAIL frame_serial k=%0d word=%h: got %h required %h", k, d, obs_ser, exp_ser);
    end
    tests++;
    if (obs_act !== exp_act) begin
      fails++;
      $display("FAIL frame_active k=%0d word=%h: got %h required %h", k, d, obs_act, exp_act);
    end
    tests++;
    if (obs_done !== exp_done) begin
      fails++;
      $display("FAIL frame_done k=%0d word=%h: got %h required %h", k, d, obs_done, exp_done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({serial[k], ready[k], active[k], done[k], st[k]} !== {4'b1100, 3'd0}) begin
        fails++;
        $display("FAIL reset_values k=%0d: ser/rdy/act/done/st got %b%b%b%b/%0d required 1100/0",
                 k, serial[k], ready[k], active[k], done[k], st[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_8n1;
    send_frame(0, 8'hA5);
  endtask

  task automatic test_parity;
    send_frame(1, 8'h07);
    send_frame(2, 8'h07);
  endtask

  task automatic test_two_stop;
    send_frame(3, 8'h7F);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        send_frame(k, 8'($urandom_range(0, 255)));
  endtask

  // Second word offered as soon as ready rises; a third is held on the bus
  // while the holding register is full and must never reach the line.
  task automatic back_to_back(input int k, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c3);
    int f = flen(k);
    offer(k, a);
    fork
      capture(k, 2 * f + 2);
      begin
        @(negedge clk);
        offer(k, b);
        @(negedge clk);
        dv[k] = 1'b1;
        byte_in[k] = c3;
        for (int i = 0; i < 6; i++) begin
          tests++;
          if (ready[k] !== 1'b0) begin
            fails++;
            $display("FAIL hold_full_ready k=%0d cycle %0d: got %b required 0", k, i, ready[k]);
          end
          @(negedge clk);
        end
        dv[k] = 1'b0;
      end
    join
    build_expect(k, 2, 2 * f + 2);
    tests++;
    if (obs_ser !== exp_ser) begin
      fails++;
      $display("FAIL b2b_serial k=%0d: got %h required %h", k, obs_ser, exp_ser);
    end
    tests++;
    if (obs_act !== exp_act) begin
      fails++;
      $display("FAIL b2b_active k=%0d: got %h required %h", k, obs_act, exp_act);
    end
    tests++;
    if (obs_done !== exp_done) begin
      fails++;
      $display("FAIL b2b_done k=%0d: got %h required %h", k, obs_done, exp_done);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_queue k=%0d: %0d words left, required 0", k, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    back_to_back(0, 8'h55, 8'hAA, 8'hF0);
    back_to_back(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h3C);
    back_to_back(3, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), 8'h11);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] a = 8'hA5;
    offer(0, a);
    offer(0, 8'h3C);
    // now one sample into START; move to the middle of data bit 3
    repeat (16) @(negedge clk);
    tests++;
    if (serial[0] !== a[3] || ready[0] !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_bit3: ser=%b rdy=%b required ser=%b rdy=0", serial[0], ready[0], a[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({serial[0], ready[0], active[0], done[0]} !== 4'b1100) begin
      fails++;
      $display("FAIL async_reset: ser/rdy/act/done got %b%b%b%b required 1100",
               serial[0], ready[0], active[0], done[0]);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    capture(0, 60);
    build_expect(0, 0, 60);
    tests++;
    if (obs_ser !== exp_ser || obs_act !== exp_act || obs_done !== exp_done) begin
      fails++;
      $display("FAIL post_reset_idle: ser=%h act=%h done=%h required ser=%h act=0 done=0",
               obs_ser, obs_act, obs_done, exp_ser);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dv = '0;
    for (int k = 0; k < 4; k++) byte_in[k] = '0;
    test_reset;
    test_8n1;
    test_parity;
    test_two_stop;
    test_random;
    test_back_to_back;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter serialising one frame per accepted word: 1 start bit, `DATA_BITS` data bits (LSB first), optional odd/even parity, then 1 or 2 stop bits. It replaces the fixed 8N1 transmitter at the host-link boundary. A one-word holding register with a ready/valid handshake allows back-to-back frames with no idle gap between them.

## Interface
- `CLKS_PER_BIT`, 217: clock cycles per bit period; legal range ≥ 2 (i_Clock frequency / baud).
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY_MODE`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal values 1 or 2.

Ports:
- `i_Clock` in 1: sole clock; all logic on the rising edge.
- `i_Rst_n` in 1: asynchronous, active-low reset.
- `i_Tx_DV` in 1: word valid; a word is accepted on an edge where `i_Tx_DV && o_Tx_Ready`.
- `i_Tx_Byte` in DATA_BITS: word to send; sampled only on acceptance.
- `o_Tx_Ready` in 0 / out 1: holding register empty; combinational decode of the hold-valid flop.
- `o_Tx_Active` out 1: high whenever the FSM is not in IDLE.
- `o_Tx_Serial` out 1: registered serial line; idle level is 1.
- `o_Tx_Done` out 1: one-cycle pulse at the end of each frame's final stop bit.

## Operation
- Storage: holding register `hold` plus `hold_v`; shift register `sh`; bit counter; baud counter of width `$clog2(CLKS_PER_BIT)`.
- Acceptance: `hold <= i_Tx_Byte`, `hold_v <= 1`. While `hold_v = 1`, `o_Tx_Ready = 0` and `i_Tx_DV` is ignored. A word is never overwritten.
- Load: `sh <= hold` and `hold_v <= 0` when (a) the FSM is in IDLE with `hold_v = 1`, or (b) the last stop bit ends with `hold_v = 1`. At a load edge `o_Tx_Ready` was low, so a load and an accept never occur on the same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial = 1. Go to START on load.
  - START: serial = 0 for one bit period, then go to DATA.
  - DATA: serial = `sh[bit_idx]`, with `bit_idx` running 0..DATA_BITS-1, one bit period each. Then go to PARITY if `PARITY_MODE != 0`, otherwise STOP.
  - PARITY: even mode sends `^sh`; odd mode sends `~^sh`. One bit period, then go to STOP.
  - STOP: serial = 1 for `STOP_BITS` periods. At the end, pulse `o_Tx_Done` and go to START if a load occurs (case b), otherwise IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and clears at each bit boundary and on any state entry.
- Parity is computed from `sh` captured at load, so it is independent of later input changes.
- Unused parameter values (for example PARITY_MODE = 3) behave as no parity. An assertion flags them in simulation.

## Timing
- Reset values (asynchronous): `o_Tx_Serial` = 1, `o_Tx_Ready` = 1, `o_Tx_Active` = 0, `o_Tx_Done` = 0. State is IDLE; `hold_v`, counters and `sh` are cleared.
- Reset mid-frame: the line returns to 1 immediately and both the in-flight word and the pending word are discarded. No `o_Tx_Done` is issued.
- Latency: word accepted on edge T; edge T+1 performs the load and enters START, so `o_Tx_Serial` falls after T+1. `o_Tx_Ready` is high again after T+1.
- Frame length: F = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × CLKS_PER_BIT cycles, from the START entry edge to the end of the last stop bit.
- `o_Tx_Done` is registered and high for exactly the one cycle following the edge that ends the last stop bit.
- Back-to-back: with `hold_v = 1` at frame end, the next start bit begins on the same edge, giving zero idle cycles. `o_Tx_Active` stays high and `o_Tx_Done` still pulses once per frame.
- Sustained throughput: one frame per F cycles when the word is presented before the load edge.

## Test plan
- CLKS_PER_BIT=4, 8N1, send 0xA5 → serial bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `o_Tx_Done` pulses 40 cycles after the START entry; `o_Tx_Active` is high for 40 cycles.
- DATA_BITS=8, PARITY_MODE=2, send 0x07 → parity bit 1. Repeat with PARITY_MODE=1 → parity bit 0. Frame length is 44 cycles.
- DATA_BITS=7, STOP_BITS=2, send 0x7F → 7 ones, then serial stays 1 for 8 cycles before `o_Tx_Done`. Total frame is 40 cycles.
- Back-to-back 8N1: send 0x55, then assert `i_Tx_DV` with 0xAA as soon as `o_Tx_Ready` rises → second start bit immediately follows the first frame's stop bit with no gap. `o_Tx_Done` pulses twice, 40 cycles apart.
- Hold full: present a third word while `o_Tx_Ready` = 0 → not accepted; the frames on the line remain 0x55 and 0xAA only.
- Assert `i_Rst_n` = 0 during data bit 3 with a word pending → `o_Tx_Serial` = 1 asynchronously and `o_Tx_Ready` = 1. After release the line stays idle and no `o_Tx_Done` occurs.
